// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor
//  Purpose  : Bit-serial unsigned subtractor. Computes diff = a - b
//             (mod 2^WIDTH) and a final borrow, one bit per clock, LSB
//             first, through a full-subtractor cell and a borrow flop.
//             Operands are loaded in parallel on a valid/ready input port
//             and the result is presented in parallel on a valid/ready
//             output port.
//  Ports    : clk        in   rising-edge clock
//             rst        in   asynchronous active-high reset
//             in_valid   in   a/b present and valid
//             in_ready   out  block can accept operands (IDLE, not in reset)
//             a          in   minuend   [WIDTH-1:0]
//             b          in   subtrahend[WIDTH-1:0]
//             out_valid  out  diff/borrow valid (DONE)
//             out_ready  in   consumer accepts result
//             diff       out  a - b mod 2^WIDTH
//             borrow     out  1 when a < b (unsigned)
//  Revision : 1.0  initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int             c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 w_in_ready;
    logic                 w_out_valid;

    // The minuend register doubles as the result register: every CALC edge
    // consumes bit 0 and shifts the new difference bit in at the MSB, so
    // after WIDTH edges it holds the complete result.
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic                 r_bf;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [WIDTH-1:0]     r_diff;
    logic                 r_borrow;

    logic                 w_a0;
    logic                 w_b0;
    logic                 w_d;
    logic                 w_bf_next;
    logic [WIDTH-1:0]     w_a_next;

    // ------------------------------------------------------------------
    // Full-subtractor cell
    // ------------------------------------------------------------------
    assign w_a0      = r_a[0];
    assign w_b0      = r_b[0];
    assign w_d       = w_a0 ^ w_b0 ^ r_bf;
    assign w_bf_next = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_bf);

    generate
        if (WIDTH == 1) begin : g_single
            assign w_a_next = w_d;
        end else begin : g_multi
            assign w_a_next = {w_d, r_a[WIDTH-1:1]};
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == c_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // The state register already sits in IDLE during reset, so in_ready is
    // additionally masked by rst to keep producers off while reset is held.
    assign in_ready  = w_in_ready & ~rst;
    assign out_valid = w_out_valid;
    assign diff      = r_diff;
    assign borrow    = r_borrow;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_bf     <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_bf  <= 1'b0;
                        r_cnt <= '0;
                    end
                end
                S_CALC: begin
                    r_a   <= w_a_next;
                    r_b   <= r_b >> 1;
                    r_bf  <= w_bf_next;
                    r_cnt <= r_cnt + c_cnt_w'(1);
                    // Publish only on the final bit so a partial result is
                    // never visible on diff/borrow.
                    if (r_cnt == c_last) begin
                        r_diff   <= w_a_next;
                        r_borrow <= w_bf_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_subtractor
//  Purpose  : Self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=1).
//             A cycle monitor compares the WIDTH=8 instance against an
//             arithmetic reference (a - b mod 256, a < b) with exact latency;
//             directed cases pin hand-computed results.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow;

    logic         u1_in_valid;
    logic         u1_in_ready;
    logic [0:0]   u1_a;
    logic [0:0]   u1_b;
    logic         u1_out_valid;
    logic         u1_out_ready;
    logic [0:0]   u1_diff;
    logic         u1_borrow;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (u1_in_valid),
        .in_ready  (u1_in_ready),
        .a         (u1_a),
        .b         (u1_b),
        .out_valid (u1_out_valid),
        .out_ready (u1_out_ready),
        .diff      (u1_diff),
        .borrow    (u1_borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference monitor for the WIDTH=8 instance (sampled on negedge)
    // ------------------------------------------------------------------
    bit           m_pend = 0;
    int           m_acc  = 0;
    logic [W-1:0] m_exp_d, m_held_d = '0;
    logic         m_exp_b, m_held_b = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            m_pend   = 0;
            m_held_d = '0;
            m_held_b = 1'b0;
            check("rst_out_valid", out_valid, 0);
            check("rst_in_ready", in_ready, 0);
            check("rst_diff", diff, 0);
            check("rst_borrow", borrow, 0);
        end else if (m_pend) begin
            if (cyc < m_acc + W) begin
                check("calc_out_valid", out_valid, 0);
                check("calc_in_ready", in_ready, 0);
                check("calc_diff_hold", diff, m_held_d);
                check("calc_borrow_hold", borrow, m_held_b);
            end else begin
                check("done_out_valid", out_valid, 1);
                check("done_in_ready", in_ready, 0);
                check("model_diff", diff, m_exp_d);
                check("model_borrow", borrow, m_exp_b);
                if (out_valid === 1'b1 && out_ready === 1'b1) begin
                    m_pend   = 0;
                    m_held_d = m_exp_d;
                    m_held_b = m_exp_b;
                end
            end
        end else begin
            check("idle_out_valid", out_valid, 0);
            check("idle_in_ready", in_ready, 1);
            check("idle_diff_hold", diff, m_held_d);
            check("idle_borrow_hold", borrow, m_held_b);
            if (in_valid === 1'b1) begin
                m_pend  = 1;
                m_acc   = cyc + 1;
                m_exp_d = W'(a - b);
                m_exp_b = (a < b);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all drives happen 1ns after a posedge)
    // ------------------------------------------------------------------
    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv);
        bit ok;
        ok       = 0;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                a        = W'($urandom);
                b        = W'($urandom);
                ok       = 1;
            end
        end
        if (!ok) begin
            in_valid = 1'b0;
            timeout_fail("send");
        end
    endtask

    task automatic recv(input int dly, output logic [W-1:0] d, output logic bo);
        bit seen;
        seen = 0;
        d    = '0;
        bo   = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                seen = 1;
                d    = diff;
                bo   = borrow;
            end
        end
        if (!seen) begin
            timeout_fail("recv");
        end else begin
            repeat (dly) @(posedge clk);
            @(posedge clk);
            #1 out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
        end
    endtask

    task automatic op_expect(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                             input logic [W-1:0] ed, input logic eb);
        logic [W-1:0] d;
        logic         bo;
        send(av, bv);
        recv(0, d, bo);
        check({name, "_diff"}, d, ed);
        check({name, "_borrow"}, bo, eb);
        @(negedge clk);
        check({name, "_in_ready_back"}, in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        logic [W-1:0] ra, rb, d;
        logic         bo;
        logic [1:0]   e;
        logic [1:0]   u1_exp [4];
        int           sel, gap;

        // {diff, borrow} for (a,b) = 00, 01, 10, 11
        u1_exp[0] = 2'b00;
        u1_exp[1] = 2'b11;
        u1_exp[2] = 2'b10;
        u1_exp[3] = 2'b00;

        rst          = 1'b1;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        a            = '0;
        b            = '0;
        u1_in_valid  = 1'b0;
        u1_out_ready = 1'b1;
        u1_a         = '0;
        u1_b         = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("u1_rst_out_valid", u1_out_valid, 0);
        check("u1_rst_in_ready", u1_in_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed arithmetic cases
        op_expect("t1_05_03", 8'h05, 8'h03, 8'h02, 1'b0);
        op_expect("t2_03_05", 8'h03, 8'h05, 8'hFE, 1'b1);
        op_expect("t2_00_FF", 8'h00, 8'hFF, 8'h01, 1'b1);
        op_expect("t3_00_00", 8'h00, 8'h00, 8'h00, 1'b0);
        op_expect("t3_FF_FF", 8'hFF, 8'hFF, 8'h00, 1'b0);

        // Back-pressure: result held, input pulses ignored
        send(8'h80, 8'h01);
        for (int k = 0; k < 100 && out_valid !== 1'b1; k++) @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            in_valid = (k % 3 == 0);
            a        = 8'h11;
            b        = 8'h00;
            @(negedge clk);
            check("t4_out_valid", out_valid, 1);
            check("t4_diff", diff, 8'h7F);
            check("t4_borrow", borrow, 0);
            check("t4_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        recv(0, d, bo);
        check("t4_final_diff", d, 8'h7F);

        // Reset three cycles into CALC
        send(8'h55, 8'h22);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("t5_out_valid", out_valid, 0);
        check("t5_diff", diff, 0);
        check("t5_borrow", borrow, 0);
        check("t5_in_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        op_expect("t5_A0_0A", 8'hA0, 8'h0A, 8'h96, 1'b0);

        // Randomized operations against the reference monitor
        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 7);
            ra  = W'($urandom);
            rb  = W'($urandom);
            if (sel == 0) rb = ra;
            else if (sel == 1) ra = '0;
            else if (sel == 2) rb = 8'hFF;
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
            send(ra, rb);
            recv($urandom_range(0, 3), d, bo);
        end

        // WIDTH=1 instance: registered half subtractor, latency 1
        for (int k = 0; k < 4; k++) begin
            e           = u1_exp[k];
            u1_a        = 1'(k >> 1);
            u1_b        = 1'(k);
            u1_in_valid = 1'b1;
            @(negedge clk);
            check("u1_in_ready", u1_in_ready, 1);
            @(posedge clk);
            #1 u1_in_valid = 1'b0;
            @(negedge clk);
            check("u1_calc_out_valid", u1_out_valid, 0);
            @(negedge clk);
            check("u1_out_valid", u1_out_valid, 1);
            check("u1_diff", u1_diff, e[1]);
            check("u1_borrow", u1_borrow, e[0]);
            @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
